// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory port arbiter: FSM state codes, owner
// codes and default address/data widths.
// Configuration macro used by the arbiter: MEM_ARB_RR_EN (round-robin).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational owner select for the shared memory port.
//   f_req, d_req : requests from fetch and data sides
//   last_owner   : owner of the most recent grant
//   grant        : 1 when at least one request is pending
//   owner        : winning requester (valid when grant=1)
// Configuration: MEM_ARB_RR_EN defined -> round-robin on contention
// (winner is the requester that did not win last time); undefined -> fixed
// priority, DATA wins contention. A lone requester always wins.
// ---------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   f_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output logic   grant,
    output owner_t owner
);

`ifndef MEM_ARB_RR_EN
    // Fixed priority keeps last_owner only for bookkeeping in the parent.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        grant = f_req | d_req;
        owner = OWN_DATA;
        if (f_req && !d_req) begin
            owner = OWN_FETCH;
        end else if (f_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            if (last_owner == OWN_DATA) begin
                owner = OWN_FETCH;
            end else begin
                owner = OWN_DATA;
            end
`else
            owner = OWN_DATA;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch and data load/store.
// A granted request is latched into the registered memory port, held for one
// access cycle, and answered with a one-cycle ack on the owner's side.
// FSM: IDLE -> ACC -> RESP -> IDLE (one transaction per three cycles).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   f_req/f_addr             fetch request (read only)
//   f_ack/f_rdata            fetch done pulse, read data held until next fetch
//   d_req/d_we/d_addr/d_wdata data request (d_we=1 store)
//   d_ack/d_rdata            data done pulse, load data held until next load
//   mem_addr/mem_din/mem_we  registered RAM port
//   mem_dout                 RAM combinational read data
//   busy                     1 whenever the FSM is not IDLE
//   dbg_state                current FSM state code
// Handshake: a request is taken when req is high while the FSM is IDLE at a
// rising edge; after that the requester's inputs are ignored until its ack
// pulse. A request still high after its ack starts a new transaction.
// Configuration macro: MEM_ARB_RR_EN (see mem_arb_pick).
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    state_t        state_q, state_d;
    owner_t        last_owner_q, last_owner_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          mem_we_q, mem_we_d;
    logic          f_ack_q, f_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] f_rdata_q, f_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic          pick_grant;
    owner_t        pick_owner;

    mem_arb_pick u_pick (
        .f_req      (f_req),
        .d_req      (d_req),
        .last_owner (last_owner_q),
        .grant      (pick_grant),
        .owner      (pick_owner)
    );

    // last_owner is updated on every grant, so during ACC/RESP it also names
    // the owner of the transaction in flight.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_we_d     = 1'b0;
        f_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        f_rdata_d    = f_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_grant) begin
                    last_owner_d = pick_owner;
                    state_d      = ST_ACC;
                    if (pick_owner == OWN_DATA) begin
                        mem_addr_d = d_addr;
                        mem_din_d  = d_wdata;
                        mem_we_d   = d_we;
                    end else begin
                        mem_addr_d = f_addr;
                    end
                end
            end
            ST_ACC: begin
                // mem_we_q still marks a store here; loads/fetches capture RAM data.
                if (!mem_we_q) begin
                    if (last_owner_q == OWN_FETCH) begin
                        f_rdata_d = mem_dout;
                    end else begin
                        d_rdata_d = mem_dout;
                    end
                end
                f_ack_d = (last_owner_q == OWN_FETCH);
                d_ack_d = (last_owner_q == OWN_DATA);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWN_DATA;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= 1'b0;
            f_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_we_q     <= mem_we_d;
            f_ack_q      <= f_ack_d;
            d_ack_q      <= d_ack_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_we    = mem_we_q;
    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a behavioural RAM
// (async read, sync write, preloaded with ram[i] = i ^ 8'h24).
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       f_req;
    logic [7:0] f_addr;
    logic       f_ack;
    logic [7:0] f_rdata;
    logic       d_req;
    logic       d_we;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic       d_ack;
    logic [7:0] d_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_we;
    logic [7:0] mem_dout;
    logic       busy;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [256];
    logic [7:0] exp_f;
    logic [7:0] exp_d;

    typedef struct {
        logic       is_fetch;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_ack     (f_ack),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_dout  (mem_dout),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / RAM model
    always #5 clk = ~clk;

    assign mem_dout = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Inputs and checks both happen #1 after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input vec_t v);
        if (v.is_fetch) begin
            f_req  = 1'b1;
            f_addr = v.addr;
        end else begin
            d_req   = 1'b1;
            d_we    = v.we;
            d_addr  = v.addr;
            d_wdata = v.wdata;
        end
        step();
        chk("acc_state", {30'd0, dbg_state}, 32'd1);
        chk("acc_busy", {31'd0, busy}, 32'd1);
        chk("acc_addr", {24'd0, mem_addr}, {24'd0, v.addr});
        chk("acc_we", {31'd0, mem_we}, {31'd0, (!v.is_fetch && v.we)});
        if (!v.is_fetch && v.we) chk("acc_din", {24'd0, mem_din}, {24'd0, v.wdata});
        // Drop and scramble inputs right after grant; the latched txn must finish.
        f_req   = 1'b0;
        d_req   = 1'b0;
        f_addr  = ~v.addr;
        d_addr  = ~v.addr;
        d_wdata = ~v.wdata;
        step();
        if (v.is_fetch) exp_f = v.exp_rdata;
        else if (!v.we) exp_d = v.exp_rdata;
        chk("resp_state", {30'd0, dbg_state}, 32'd2);
        chk("resp_f_ack", {31'd0, f_ack}, {31'd0, v.is_fetch});
        chk("resp_d_ack", {31'd0, d_ack}, {31'd0, !v.is_fetch});
        chk("resp_we", {31'd0, mem_we}, 32'd0);
        chk("resp_f_rdata", {24'd0, f_rdata}, {24'd0, exp_f});
        chk("resp_d_rdata", {24'd0, d_rdata}, {24'd0, exp_d});
        step();
        chk("idle_acks", {30'd0, f_ack, d_ack}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_ack(output logic fa, output logic da);
        bit found = 1'b0;
        fa = 1'b0;
        da = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step();
            if (f_ack || d_ack) begin
                fa = f_ack;
                da = d_ack;
                found = 1'b1;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout act=none exp=ack_within_8");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_f = 8'h00;
        exp_d = 8'h00;
    endtask

    initial begin
        logic fa, da;
        logic [1:0] exp_seq [4];

        for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h24;
        rst = 1'b1; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0;

        vecs[0] = '{1'b1, 1'b0, 8'h02, 8'h00, 8'h26};
        vecs[1] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
        vecs[4] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hDB};
        vecs[5] = '{1'b0, 1'b1, 8'hFF, 8'h3C, 8'h00};
        vecs[6] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h24};

        // reset state
        do_reset();
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acks", {30'd0, f_ack, d_ack}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
        chk("rst_rdata", {16'd0, f_rdata, d_rdata}, 32'd0);

        // single transactions from the vector table
        for (int i = 0; i < 8; i++) run_single(vecs[i]);

        // contention with both requests held
        do_reset();
`ifdef MEM_ARB_RR_EN
        exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        f_req = 1'b1; f_addr = 8'h02;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h05;
        for (int i = 0; i < 4; i++) begin
            wait_ack(fa, da);
            chk("cont_owner", {30'd0, fa, da}, {30'd0, exp_seq[i]});
            if (fa) chk("cont_f_rdata", {24'd0, f_rdata}, 32'h26);
            if (da) chk("cont_d_rdata", {24'd0, d_rdata}, 32'h21);
        end
        d_req = 1'b0;
        wait_ack(fa, da);
        chk("cont_after_drop", {30'd0, fa, da}, 32'b10);
        chk("cont_after_f_rdata", {24'd0, f_rdata}, 32'h26);
        f_req = 1'b0;
        step(); step(); step();

        // reset coinciding with grant edge: store never happens
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 8'h77;
        rst = 1'b1;
        step();
        chk("rst_grant_state", {30'd0, dbg_state}, 32'd0);
        chk("rst_grant_we", {31'd0, mem_we}, 32'd0);
        rst = 1'b0; d_req = 1'b0;
        exp_f = 8'h00; exp_d = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_grant_noack", {30'd0, f_ack, d_ack}, 32'd0);
        end
        run_single('{1'b0, 1'b0, 8'h30, 8'h00, 8'h14});

        // reset while the store is in ACC
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_wdata = 8'h99;
        step();
        chk("racc_we_before", {31'd0, mem_we}, 32'd1);
        d_req = 1'b0;
        rst = 1'b1;
        step();
        chk("racc_we", {31'd0, mem_we}, 32'd0);
        chk("racc_acks", {30'd0, f_ack, d_ack}, 32'd0);
        chk("racc_busy", {31'd0, busy}, 32'd0);
        chk("racc_addr", {24'd0, mem_addr}, 32'd0);
        chk("racc_din", {24'd0, mem_din}, 32'd0);
        chk("racc_rdata", {16'd0, f_rdata, d_rdata}, 32'd0);
        rst = 1'b0;
        exp_f = 8'h00; exp_d = 8'h00;
        step();
        chk("racc_noack", {30'd0, f_ack, d_ack}, 32'd0);

        // idle with no requests for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_quiet", {28'd0, busy, mem_we, f_ack, d_ack}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
